// File: rtl/tmr_ctrl_fsm_pkg.sv
// Shared definitions for the timer run/pause/stop controller.
package tmr_ctrl_fsm_pkg;

    // Controller states; the three spare encodings of the 3-bit register recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } tmr_state_e;

    // A run is in progress from the load cycle until it completes or is aborted.
    function automatic logic is_busy(input tmr_state_e st);
        return (st == ST_LOAD) || (st == ST_RUN) || (st == ST_PAUSE);
    endfunction

endpackage

// File: rtl/tick_prescale_nb.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the last count as a tick.
module tick_prescale_nb #(
    parameter int PRESCALE = 100000,
    parameter int PS_W     = 17
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic rst_cnt,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_r;
    logic [PS_W-1:0] cnt_nxt_s;

    // Next count: zero on request, wrap at the last count, otherwise hold when disabled.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (rst_cnt) begin
            cnt_nxt_s = {PS_W{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_nxt_s = {PS_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + PS_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Prescaler count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {PS_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // The tick comes only from registered count and the (registered-state) enable.
    assign tick = (cnt_r == LAST) & en;

endmodule

// File: rtl/tmr_ctrl_fsm.sv
// Timer front end: sequences clear/load/count of an external up counter and
// detects its wrap to zero through the counter's ripple-carry-out.
module tmr_ctrl_fsm
    import tmr_ctrl_fsm_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 100000,
    parameter int PS_W     = 17
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         stop,
    input  logic [N-1:0] preset,
    input  logic         rco_in,
    output logic         cnt_clr,
    output logic         cnt_ld,
    output logic         cnt_up,
    output logic [N-1:0] cnt_D,
    output logic         busy,
    output logic         done
);

    tmr_state_e   state_r;
    tmr_state_e   state_nxt_s;
    logic [N-1:0] cnt_d_r;
    logic [N-1:0] cnt_d_nxt_s;
    logic         ps_en_s;
    logic         ps_rst_s;
    logic         tick_s;

    // The prescaler advances only in RUN; it is held at zero outside a run so
    // every fresh run starts a full prescale period after LOAD. PAUSE freezes it.
    assign ps_en_s  = (state_r == ST_RUN);
    assign ps_rst_s = (state_r == ST_LOAD) || (state_r == ST_IDLE) || (state_r == ST_DONE);

    tick_prescale_nb #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_ps (
        .clk     (clk),
        .clr     (clr),
        .en      (ps_en_s),
        .rst_cnt (ps_rst_s),
        .tick    (tick_s)
    );

    // Next-state and preset capture; stop always wins over start, and a
    // terminal tick wins over stop because the counter has already wrapped.
    always_comb begin
        state_nxt_s = state_r;
        cnt_d_nxt_s = cnt_d_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    state_nxt_s = ST_LOAD;
                    cnt_d_nxt_s = preset;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (tick_s && rco_in) begin
                    state_nxt_s = ST_DONE;
                end else if (stop) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and captured-preset registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_d_r <= {N{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_d_r <= cnt_d_nxt_s;
        end
    end

    // Moore decode from registered state only.
    assign cnt_clr = (state_r == ST_IDLE);
    assign cnt_ld  = (state_r == ST_LOAD);
    assign cnt_up  = tick_s;
    assign cnt_D   = cnt_d_r;
    assign busy    = is_busy(state_r);
    assign done    = (state_r == ST_DONE);

endmodule
